// File: rtl/avalon_st_pkg.sv
// Shared constants, types and helpers for the Avalon-ST sink receive path.
package avalon_st_pkg;

    localparam int MAX_READY_LATENCY = 4;
    localparam int DROP_CNT_BITS     = 8;

    typedef logic [DROP_CNT_BITS-1:0] drop_cnt_t;

    localparam drop_cnt_t DROP_CNT_MAX = 8'hFF;
    localparam drop_cnt_t DROP_CNT_ONE = 8'h01;

    function automatic int beat_width(input int symbols, input int bits);
        return symbols * bits;
    endfunction

endpackage

// File: rtl/avalon_sink_buf.sv
// Show-ahead dual-pointer FIFO holding accepted beats for the sink's local read port.
module avalon_sink_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [DEPTH:0]   used
);

    localparam logic [DEPTH-1:0] PTR_ONE = DEPTH'(1);
    localparam logic [DEPTH:0]   CNT_ONE = (DEPTH+1)'(1);
    localparam logic [DEPTH:0]   CAPACITY = (DEPTH+1)'(2**DEPTH);

    logic [WIDTH-1:0] mem_r [2**DEPTH];
    logic [DEPTH-1:0] wr_ptr_r;
    logic [DEPTH-1:0] rd_ptr_r;
    logic [DEPTH:0]   used_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests against the registered occupancy so pointers never run past each other.
    always_comb begin
        push_ok_s = push && (used_r != CAPACITY);
        pop_ok_s  = pop && (used_r != '0);
    end

    // Storage, pointers and occupancy; memory is cleared so rd_data reads zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            used_r   <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   used_r <= used_r + CNT_ONE;
                2'b01:   used_r <= used_r - CNT_ONE;
                default: used_r <= used_r;
            endcase
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign empty   = (used_r == '0);
    assign full    = (used_r == CAPACITY);
    assign used    = used_r;

endmodule

// File: rtl/avalon_st_sink_rx.sv
// Avalon-ST sink: ready generation with latency headroom, ready-window legality check,
// drop/error reporting, and a show-ahead buffer toward local logic.
module avalon_st_sink_rx
    import avalon_st_pkg::*;
#(
    parameter int DATABITS_PER_SYMBOL = 8,
    parameter int SYMBOLS_PER_BEAT    = 4,
    parameter int READY_LATENCY       = 2,
    parameter int DEPTH               = 4,
    localparam int WIDTH = beat_width(SYMBOLS_PER_BEAT, DATABITS_PER_SYMBOL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    input  logic             rd_req,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_empty,
    output logic [DEPTH:0]   used,
    output logic             proto_err,
    output drop_cnt_t        drop_cnt
);

    // Deassert ready while READY_LATENCY+1 slots are still free so in-flight beats always fit.
    localparam logic [DEPTH:0] READY_THRESH = (DEPTH+1)'(2**DEPTH - READY_LATENCY - 1);
    localparam logic [MAX_READY_LATENCY:0] WINDOW_SEL =
        (MAX_READY_LATENCY+1)'(1) << READY_LATENCY;

    logic                         rst_q_r;
    logic [MAX_READY_LATENCY-1:0] rdy_hist_r;
    logic [MAX_READY_LATENCY:0]   rdy_hist_s;
    logic                         proto_err_r;
    drop_cnt_t                    drop_cnt_r;

    logic             ready_s;
    logic             window_s;
    logic             legal_s;
    logic             accept_s;
    logic             drop_s;
    logic             pop_s;
    logic             buf_full_s;
    logic             buf_empty_s;
    logic [DEPTH:0]   buf_used_s;
    logic [WIDTH-1:0] buf_rd_data_s;

    // Ready and beat legality; bit k of rdy_hist_s is ready delayed k cycles.
    always_comb begin
        ready_s    = !rst_q_r && (buf_used_s <= READY_THRESH);
        rdy_hist_s = {rdy_hist_r, ready_s};
        window_s   = |(rdy_hist_s & WINDOW_SEL);
        legal_s    = valid && window_s;
        accept_s   = legal_s && !buf_full_s;
        drop_s     = (valid && !window_s) || (legal_s && buf_full_s);
        pop_s      = rd_req && !buf_empty_s;
    end

    // Ready history, registered reset, sticky error flag and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_q_r     <= 1'b1;
            rdy_hist_r  <= '0;
            proto_err_r <= 1'b0;
            drop_cnt_r  <= '0;
        end else begin
            rst_q_r    <= 1'b0;
            rdy_hist_r <= rdy_hist_s[MAX_READY_LATENCY-1:0];
            if (drop_s) begin
                proto_err_r <= 1'b1;
            end
            if (drop_s && (drop_cnt_r != DROP_CNT_MAX)) begin
                drop_cnt_r <= drop_cnt_r + DROP_CNT_ONE;
            end
        end
    end

    avalon_sink_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (accept_s),
        .push_data (data),
        .pop       (pop_s),
        .rd_data   (buf_rd_data_s),
        .empty     (buf_empty_s),
        .full      (buf_full_s),
        .used      (buf_used_s)
    );

    assign ready     = ready_s;
    assign rd_data   = buf_rd_data_s;
    assign rd_empty  = buf_empty_s;
    assign used      = buf_used_s;
    assign proto_err = proto_err_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: doc/avalon_st_sink_rx.md
Name: avalon_st_sink_rx

Overview:
- Avalon-ST sink endpoint; the receiving end of the stream a FIFO source drives through the interface's sink modport.
- Accepts beats under a configurable ready latency and buffers them internally, including beats already in flight when ready drops.
- Presents them to local logic through a show-ahead read port.
- Detects protocol violations from the source: beats arriving outside the ready window.

Parameters:
- DATABITS_PER_SYMBOL, 8, bits per symbol.
- SYMBOLS_PER_BEAT, 4, symbols per beat; WIDTH = SYMBOLS_PER_BEAT*DATABITS_PER_SYMBOL.
- READY_LATENCY, 2, cycles from ready assertion to the earliest legal valid beat; range 0..4.
- DEPTH, 4, buffer address bits; capacity 2**DEPTH words; 2**DEPTH must exceed READY_LATENCY+1.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- valid  in  1  source beat valid.
- data  in  WIDTH  source beat data.
- ready  out  1  sink ready to source.
- rd_req  in  1  pop head word.
- rd_data  out  WIDTH  head word; show-ahead, meaningful when !rd_empty.
- rd_empty  out  1  buffer empty.
- used  out  DEPTH+1  words stored.
- proto_err  out  1  sticky: beat seen outside ready window, or buffer overflow.
- drop_cnt  out  8  saturating count of dropped beats.

Behaviour:
- Reset: clears buffer, pointers, count, ready-history shift register, proto_err and drop_cnt.
  - Output values during and after reset: ready=0, rd_empty=1, used=0, rd_data=0.
  - A reset mid-stream discards all stored words.
- ready
  - Combinational from registered count only; no comb path from valid, data or rd_req.
  - ready = !rst_q && (used <= 2**DEPTH - READY_LATENCY - 1).
  - rst_q is rst registered, so ready rises no earlier than one cycle after rst falls.
- Window
  - rdy_hist[k] holds ready delayed k cycles; rdy_hist[0] = ready.
  - Beat at cycle n is legal iff valid && rdy_hist[READY_LATENCY] at cycle n.
  - READY_LATENCY=0: legal iff valid && ready, same cycle.
- Accept
  - A legal beat with the buffer not full is written at the write pointer.
  - Write pointer and used increment next edge.
- Illegal beat (valid while the delayed ready is 0): not stored; proto_err set; drop_cnt increments.
- Overflow (legal beat while used == 2**DEPTH): unreachable when the ready rule holds. Beat dropped; proto_err set; drop_cnt increments.
- drop_cnt saturates at 255. proto_err clears only on rst.
- Read
  - rd_data always reflects the word at the read pointer.
  - rd_req && !rd_empty advances the read pointer next edge.
  - rd_req while empty is ignored with no error; the pointer does not move.
- Simultaneous push and pop: used unchanged, both pointers advance.
  - Push into an empty buffer makes rd_empty fall the next cycle (write-to-read latency 1).
  - No same-cycle bypass.
- Pointers: DEPTH-bit, natural wrap modulo 2**DEPTH. used is the DEPTH+1-bit counter, so full and empty are unambiguous.
- Headroom: since ready is deasserted with READY_LATENCY+1 free slots, every beat already in flight when ready falls is absorbed without loss.

Decomposition:
- Package avalon_st_pkg
  - Function beat_width(symbols, bits).
  - Localparam MAX_READY_LATENCY = 4.
  - Typedef for drop-counter width (8 bits).
- Sub-module avalon_sink_buf
  - Parameterised by WIDTH and DEPTH.
  - Simple dual-pointer RAM FIFO with push, pop, show-ahead data, used count.
- Top level holds the ready rule, ready-history shift register, legality check and error/drop logic.

Test Plan:
- Reset then stream 20 beats 0x00000001..0x00000014 under a legal source (L=2), rd_req held 1 -> all 20 words read in order, proto_err=0, drop_cnt=0, ready never falls.
- Same 20 beats with rd_req=0 -> ready falls once used reaches 14 (DEPTH=4, L=2). In-flight beats fill used to 16 and are not lost. Draining reads 0x01..0x10 in order, and the remaining beats follow after ready reasserts.
- Source drives valid=1 on the cycle after reset deasserts, while rdy_hist[2]=0 -> beat not stored, proto_err=1, drop_cnt=1, used stays 0.
- rd_req pulsed on an empty buffer for 3 cycles, then one legal beat 0xDEADBEEF -> no pointer motion and no error. rd_empty falls one cycle after the accept edge with rd_data=0xDEADBEEF.
- Push and pop every cycle at used=8 for 32 cycles, crossing the wrap point -> used constant 8, data order preserved across the wrap.
- Assert rst mid-stream at used=10 -> next cycle used=0, rd_empty=1, ready=0, proto_err=0. Stream resumes cleanly after ready reasserts.
